// File: rtl/stream_packet_engine_if.sv
// ----------------------------------------------------------------------------
// stream_packet_engine_if
//   Groups the user-side signals of the receive and transmit FIFOs that the
//   packet engine sits between.
//
//   Receive side : rdempty (FIFO empty), rdata (show-ahead head word),
//                  rdack (pop head this cycle)
//   Transmit side: wrfull (FIFO full), wrreq (push this cycle),
//                  wdata (word to push)
//
//   master modport: the packet engine (consumes rx words, produces tx words)
//   slave  modport: the FIFO side (provides rx words, accepts tx words)
// ----------------------------------------------------------------------------
interface stream_packet_engine_if #(
    parameter int DATAWIDTH = 32
);
    logic                 rdempty;
    logic [DATAWIDTH-1:0] rdata;
    logic                 rdack;
    logic                 wrfull;
    logic                 wrreq;
    logic [DATAWIDTH-1:0] wdata;

    modport master (
        input  rdempty,
        input  rdata,
        input  wrfull,
        output rdack,
        output wrreq,
        output wdata
    );

    modport slave (
        output rdempty,
        output rdata,
        output wrfull,
        input  rdack,
        input  wrreq,
        input  wdata
    );
endinterface

// File: rtl/stream_packet_engine.sv
// ----------------------------------------------------------------------------
// stream_packet_engine
//   Pops packets (header + len payload words) from the receive FIFO,
//   processes them according to the header opcode and pushes the results
//   into the transmit FIFO.
//
//   Header: [31:24] opcode, [23:16] ignored, [15:0] payload length.
//   Opcodes: 0x01 ECHO (word), 0x02 INC (word+1), 0x03 SUM (one result),
//            0x04 XOR (one result); anything else is an error packet whose
//            payload is discarded and which emits 32'hBAD0_0000 | opcode.
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous, active-high reset
//     fifo       stream_packet_engine_if.master (rx pop / tx push handshakes)
//     busy       high whenever a packet is in progress (state != IDLE)
//     pkt_count  packets completed, wraps
//     err_count  error packets completed, wraps
// ----------------------------------------------------------------------------
module stream_packet_engine #(
    parameter int DATAWIDTH = 32,
    parameter int LENWIDTH  = 16,
    parameter int CNTWIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    stream_packet_engine_if.master     fifo,
    output logic                       busy,
    output logic [CNTWIDTH-1:0]        pkt_count,
    output logic [CNTWIDTH-1:0]        err_count
);

    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_INC  = 8'h02;
    localparam logic [7:0] OP_SUM  = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;

    localparam logic [DATAWIDTH-1:0] ERR_TAG = DATAWIDTH'(32'hBAD0_0000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [7:0]           opcode;
    logic [LENWIDTH-1:0]  remaining;
    logic [DATAWIDTH-1:0] acc;

    logic [7:0]           hdr_op;
    logic [LENWIDTH-1:0]  hdr_len;
    logic                 word_accept;
    logic                 last_word;
    logic                 pkt_inc;
    logic                 err_inc;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_INC) || (op == OP_SUM) || (op == OP_XOR);
    endfunction

    // SUM and XOR fold the payload into acc and never write per word.
    function automatic logic is_reduce_op(input logic [7:0] op);
        return (op == OP_SUM) || (op == OP_XOR);
    endfunction

    function automatic logic [DATAWIDTH-1:0] stream_word(input logic [7:0] op,
                                                         input logic [DATAWIDTH-1:0] w);
        return (op == OP_INC) ? w + DATAWIDTH'(1) : w;
    endfunction

    function automatic logic [DATAWIDTH-1:0] reduce_word(input logic [7:0] op,
                                                         input logic [DATAWIDTH-1:0] a,
                                                         input logic [DATAWIDTH-1:0] w);
        return (op == OP_SUM) ? a + w : a ^ w;
    endfunction

    assign hdr_op    = fifo.rdata[31:24];
    assign hdr_len   = fifo.rdata[LENWIDTH-1:0];
    assign last_word = (remaining == LENWIDTH'(1));

    // Streaming opcodes need room in the tx FIFO to take a word; reductions
    // only need a word to be present.
    assign word_accept = !fifo.rdempty && (is_reduce_op(opcode) || !fifo.wrfull);

    assign busy = !reset && (state != IDLE);

    always_comb begin
        state_next = state;
        fifo.rdack = 1'b0;
        fifo.wrreq = 1'b0;
        fifo.wdata = '0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo.rdempty) begin
                    fifo.rdack = 1'b1;
                    if (!is_valid_op(hdr_op)) begin
                        state_next = (hdr_len == '0) ? EMIT : DRAIN;
                    end else if (hdr_len != '0) begin
                        state_next = DATA;
                    end else if (is_reduce_op(hdr_op)) begin
                        state_next = EMIT;
                    end else begin
                        pkt_inc = 1'b1;
                    end
                end
            end

            DATA: begin
                if (word_accept) begin
                    fifo.rdack = 1'b1;
                    if (!is_reduce_op(opcode)) begin
                        fifo.wrreq = 1'b1;
                        fifo.wdata = stream_word(opcode, fifo.rdata);
                    end
                    if (last_word) begin
                        if (is_reduce_op(opcode)) begin
                            state_next = EMIT;
                        end else begin
                            state_next = IDLE;
                            pkt_inc    = 1'b1;
                        end
                    end
                end
            end

            DRAIN: begin
                if (!fifo.rdempty) begin
                    fifo.rdack = 1'b1;
                    if (last_word) begin
                        state_next = EMIT;
                    end
                end
            end

            EMIT: begin
                if (!fifo.wrfull) begin
                    fifo.wrreq = 1'b1;
                    state_next = IDLE;
                    if (is_valid_op(opcode)) begin
                        fifo.wdata = acc;
                        pkt_inc    = 1'b1;
                    end else begin
                        fifo.wdata = ERR_TAG | DATAWIDTH'(opcode);
                        err_inc    = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

        // Handshakes are silenced for the whole reset cycle, not just after it.
        if (reset) begin
            state_next = IDLE;
            fifo.rdack = 1'b0;
            fifo.wrreq = 1'b0;
            fifo.wdata = '0;
            pkt_inc    = 1'b0;
            err_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            state <= state_next;

            if (state == IDLE && fifo.rdack) begin
                opcode    <= hdr_op;
                remaining <= hdr_len;
                acc       <= '0;
            end else if ((state == DATA || state == DRAIN) && fifo.rdack) begin
                remaining <= remaining - LENWIDTH'(1);
                if (state == DATA && is_reduce_op(opcode)) begin
                    acc <= reduce_word(opcode, acc, fifo.rdata);
                end
            end

            if (pkt_inc) pkt_count <= pkt_count + CNTWIDTH'(1);
            if (err_inc) err_count <= err_count + CNTWIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_packet_engine.sv
module tb_stream_packet_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    stream_packet_engine_if #(.DATAWIDTH(32)) ifc ();

    stream_packet_engine #(
        .DATAWIDTH(32),
        .LENWIDTH (16),
        .CNTWIDTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fifo     (ifc),
        .busy     (busy),
        .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Receive FIFO model, pending (held back) words, and the scoreboard.
    logic [31:0] rxq[$];
    logic [31:0] pendq[$];
    logic [31:0] expq[$];
    int          out_cyc[$];
    logic [31:0] pay[8];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic        wr_full = 1'b0;
    logic        last_rdack;
    logic [15:0] exp_pkt = 16'd0;
    logic [15:0] exp_err = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample 1ns later,
    // then let the rising edge happen and retire any popped rx word.
    task automatic tick();
        ifc.rdempty = (rxq.size() == 0);
        ifc.rdata   = (rxq.size() != 0) ? rxq[0] : 32'h0;
        ifc.wrfull  = wr_full;
        #1;
        last_rdack = ifc.rdack;
        check("protocol", {29'd0, ifc.rdack & ifc.rdempty, ifc.wrreq & ifc.wrfull,
                           (!ifc.wrreq && ifc.wdata != 32'h0)}, 32'h0);
        if (ifc.wrreq === 1'b1) begin
            n_out++;
            out_cyc.push_back(cyc);
            checks++;
            assert (expq.size() != 0)
            else begin
                errors++;
                $error("FAIL extra_output observed=%h expected=none", ifc.wdata);
            end
            if (expq.size() != 0) check("wdata", ifc.wdata, expq.pop_front());
        end
        @(posedge clk);
        if (last_rdack === 1'b1 && rxq.size() != 0) void'(rxq.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    // Queue a packet (header + pay[0..len-1]) and record its expected output.
    // With hold set, payload words go to pendq and are released one at a time.
    task automatic send_pkt(input logic [31:0] hdr, input bit hold);
        logic [7:0]  op;
        int          len;
        logic [31:0] acc;
        op  = hdr[31:24];
        len = int'(hdr[15:0]);
        acc = 32'h0;
        rxq.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            if (hold) pendq.push_back(pay[i]);
            else      rxq.push_back(pay[i]);
            case (op)
                8'h01: expq.push_back(pay[i]);
                8'h02: expq.push_back(pay[i] + 32'd1);
                8'h03: acc = acc + pay[i];
                8'h04: acc = acc ^ pay[i];
                default: ;
            endcase
        end
        if (op == 8'h03 || op == 8'h04) begin
            expq.push_back(acc);
            exp_pkt++;
        end else if (op == 8'h01 || op == 8'h02) begin
            exp_pkt++;
        end else begin
            expq.push_back(32'hBAD0_0000 | {24'h0, op});
            exp_err++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((expq.size() != 0 || rxq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        tick();
        check({tag, "_drained"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        ifc.rdempty = 1'b1;
        ifc.rdata   = 32'h0;
        ifc.wrfull  = 1'b0;
        @(negedge clk);

        // Reset: a waiting word must not be popped while reset is high.
        rxq.push_back(32'h0100_0000);
        tick();
        check("rst_rdack", {31'd0, last_rdack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rxq.delete();
        reset = 1'b0;
        tick();
        check("rst_pkt", {16'd0, pkt_count}, 32'd0);
        check("rst_err", {16'd0, err_count}, 32'd0);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);

        // ECHO, three words in consecutive cycles.
        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
        out_cyc.delete();
        send_pkt(32'h0100_0003, 1'b0);
        drain("echo");
        check("echo_consec", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        check("echo_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // SUM with wrap, then SUM with no payload.
        pay[0] = 32'hFFFF_FFFF; pay[1] = 32'h0000_0003;
        send_pkt(32'h0300_0002, 1'b0);
        send_pkt(32'h0300_0000, 1'b0);
        drain("sum");
        check("sum_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // INC with a 5-cycle full window after two outputs.
        pay[0] = 32'd0; pay[1] = 32'd1; pay[2] = 32'd2; pay[3] = 32'd3;
        begin
            int base;
            int n;
            base = n_out;
            n = 0;
            send_pkt(32'h0200_0004, 1'b0);
            while (n_out < base + 2 && n < 50) begin
                tick();
                n++;
            end
            check("inc_reached2", 32'(n_out - base), 32'd2);
            wr_full = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                check("bp_rdack", {31'd0, last_rdack}, 32'd0);
                check("bp_busy", {31'd0, busy}, 32'd1);
            end
            wr_full = 1'b0;
            drain("inc");
            check("inc_count", 32'(n_out - base), 32'd4);
        end
        check("inc_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // Unknown opcode with payload, followed by an XOR packet.
        pay[0] = 32'hAA; pay[1] = 32'hBB;
        send_pkt(32'h7F00_0002, 1'b0);
        pay[0] = 32'hF0; pay[1] = 32'h0F;
        send_pkt(32'h0400_0002, 1'b0);
        drain("bad");
        check("bad_err", {16'd0, err_count}, {16'd0, exp_err});
        check("bad_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // Reset after two of five ECHO words.
        for (int i = 0; i < 5; i++) pay[i] = 32'h100 + 32'(i);
        begin
            int base;
            int n;
            base = n_out;
            n = 0;
            send_pkt(32'h0100_0005, 1'b0);
            while (n_out < base + 2 && n < 50) begin
                tick();
                n++;
            end
            check("mid_reached2", 32'(n_out - base), 32'd2);
        end
        reset = 1'b1;
        ifc.rdempty = (rxq.size() == 0);
        ifc.rdata   = rxq[0];
        ifc.wrfull  = 1'b0;
        #1;
        check("mid_rst_rdack", {31'd0, ifc.rdack}, 32'd0);
        check("mid_rst_wrreq", {31'd0, ifc.wrreq}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        rxq.delete();
        expq.delete();
        exp_pkt = 16'd0;
        exp_err = 16'd0;
        tick();
        check("mid_pkt", {16'd0, pkt_count}, 32'd0);
        check("mid_err", {16'd0, err_count}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        pay[0] = 32'h5A;
        send_pkt(32'h0100_0001, 1'b0);
        drain("post_rst");
        check("post_rst_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // XOR with the receive FIFO running dry between payload words.
        pay[0] = 32'h0F0F_0000; pay[1] = 32'h00F0_F0F0; pay[2] = 32'h1234_5678;
        send_pkt(32'h0400_0003, 1'b1);
        for (int w = 0; w < 3; w++) begin
            int n;
            n = 0;
            rxq.push_back(pendq.pop_front());
            while (rxq.size() != 0 && n < 20) begin
                tick();
                n++;
            end
            if (w < 2) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("gap_busy", {31'd0, busy}, 32'd1);
                end
            end
        end
        drain("xor_gap");
        check("xor_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_packet_engine.md
Name: stream_packet_engine

Overview:
Custom-logic stage that consumes the word stream AHB writes push into the slave's receive FIFO. It pops packets, each a header plus N payload words, processes them, and pushes results into the transmit FIFO. The AHB master drains that FIFO through buffer reads. It sits between the two FIFOs, on their user-side ports.

Parameters:
DATAWIDTH, 32, width of FIFO words; header layout below requires 32.
LENWIDTH, 16, width of the payload-length field and of the remaining-word counter.
CNTWIDTH, 16, width of the packet and error counters.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
rdempty  input  1  receive FIFO empty.
rdata  input  DATAWIDTH  receive FIFO head word; show-ahead, valid whenever rdempty=0.
rdack  output  1  pop receive FIFO head this cycle.
wrfull  input  1  transmit FIFO full.
wrreq  output  1  push wdata into transmit FIFO this cycle.
wdata  output  DATAWIDTH  transmit FIFO write data.
busy  output  1  high whenever state != IDLE.
pkt_count  output  CNTWIDTH  packets completed, wraps modulo 2^CNTWIDTH.
err_count  output  CNTWIDTH  packets with unknown opcode, wraps modulo 2^CNTWIDTH.

Behaviour:
- Header word fields: [31:24] opcode, [23:16] ignored, [15:0] len, the number of payload words that follow.
- Opcodes:
  - 0x01 ECHO: output = payload word.
  - 0x02 INC: output = word+1 mod 2^32.
  - 0x03 SUM: one output = sum of words mod 2^32.
  - 0x04 XOR: one output = XOR of words.
  - Any other opcode is an error.
- rdack and wrreq are combinational. rdack is never high when rdempty=1; wrreq is never high when wrfull=1. Both are forced to 0 while reset=1.
- Reset (synchronous): state=IDLE, acc=0, remaining=0, pkt_count=0, err_count=0. busy=0, rdack=0, wrreq=0, wdata=0. Reset asserted mid-packet abandons the packet; no FIFO flush is done here.
- States are IDLE, DATA, DRAIN, EMIT.
- IDLE:
  - If rdempty=0: rdack=1 (header popped). Latch opcode, set remaining=len, clear acc.
  - Valid opcode with len>0: go to DATA.
  - SUM or XOR with len=0: go to EMIT with acc=0.
  - ECHO or INC with len=0: stay IDLE, pkt_count+1.
  - Invalid opcode: go to DRAIN, or straight to EMIT if len=0.
- DATA:
  - Word accepted when rdempty=0 AND (opcode is SUM/XOR OR wrfull=0).
  - On accept: rdack=1, remaining-1.
    - ECHO/INC: wrreq=1 in the same cycle, wdata=processed word; zero added latency.
    - SUM/XOR: acc updated at the clock edge.
  - After the last word: SUM/XOR go to EMIT; ECHO/INC go to IDLE with pkt_count+1.
  - wrfull stalls ECHO/INC with no pop and no data loss. rdempty stalls all opcodes.
- DRAIN: rdack=1 whenever rdempty=0, nothing written. After the last word, go to EMIT.
- EMIT:
  - wrreq=1 when wrfull=0.
  - wdata = acc for SUM/XOR, or 32'hBAD0_0000 | opcode for an error packet.
  - When the write occurs: go to IDLE. pkt_count+1, or err_count+1 for an error packet (pkt_count unchanged).
- wdata=0 in any cycle where wrreq=0.
- Back-to-back packets: a header may be popped in the cycle after a packet completes. Minimum one IDLE cycle per packet.
- Throughput: one payload word per cycle when the FIFOs are neither empty nor full.

Test Plan:
- ECHO: push 0x0100_0003, 0x11, 0x22, 0x33 -> transmit FIFO gets 0x11, 0x22, 0x33 in consecutive cycles; pkt_count=1.
- SUM wrap: push 0x0300_0002, 0xFFFF_FFFF, 0x0000_0003 -> single output 0x0000_0002; SUM with len=0 -> output 0x0000_0000.
- INC with backpressure: push 0x0200_0004, 0..3 with wrfull held high 5 cycles mid-packet -> outputs 1, 2, 3, 4; no rdack while wrfull=1; nothing lost or duplicated.
- Bad opcode: push 0x7F00_0002, 0xAA, 0xBB, then 0x0400_0002, 0xF0, 0x0F -> outputs 0xBAD0_007F then 0x0000_00FF; err_count=1, pkt_count=1.
- Reset mid-packet: assert reset for 1 cycle after 2 of 5 ECHO words -> busy=0, counters=0, wrreq/rdack=0 during reset; next header processed normally.
- Empty stalls: insert rdempty gaps between XOR payload words -> result unchanged, busy held high throughout.
